regfile_read_8x16: RTL and testbench
====================================

# regfile_read_8x16

Eight-entry, 16-bit register file for the RISC16bit datapath. It is the read-side counterpart of the loadable 16-bit register: it stores values written through a `D`/`Load` port and returns them through two independent, registered read ports. These ports feed the ALU operand latches. R0 is hardwired to zero.

## Interface

Parameters:
- `WIDTH`, 16, data width of each register and read port
- `DEPTH`, 8, number of registers
- `AW`, 3, address width (log2 DEPTH)

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge
- `rst`  in  1  synchronous, active-high reset
- `Load`  in  1  write enable; writes `D` to register `WA` at the rising edge
- `WA`  in  AW  write address
- `D`  in  WIDTH  write data
- `RE_A`  in  1  read request, port A
- `RA_A`  in  AW  read address, port A
- `QA`  out  WIDTH  read data, port A
- `VA`  out  1  port A data valid
- `RE_B`  in  1  read request, port B
- `RA_B`  in  AW  read address, port B
- `QB`  out  WIDTH  read data, port B
- `VB`  out  1  port B data valid

## Operation

- Storage: DEPTH x WIDTH registers. R0 always reads 0, and writes to R0 are discarded.
- Write: `Load`=1 with `WA`!=0 updates the register at the edge. `Load`=0 leaves storage unchanged.
- Each read port is a two-state machine:
  - IDLE -> VALID when `RE`=1.
  - VALID -> VALID while `RE`=1.
  - VALID -> IDLE when `RE`=0.
- In VALID, `Q` holds the data sampled for the address presented on the previous edge, and `V`=1.
- Holding behaviour: in IDLE, `V`=0 and `Q` keeps its last value; it is not cleared.
- Ports A and B are fully independent. Both may read the same address in the same cycle, and both see identical data.
- Same-cycle write and read of the same nonzero address: behaviour depends on `REGFILE_BYPASS_EN` (see Configuration).
- Reset values: every register = 0, `QA`=`QB`=0, `VA`=`VB`=0, both ports IDLE.
- Reset priority: `rst` overrides `Load` and `RE` in the same cycle. Reset asserted mid-read drops `V` and clears `Q` at that edge.
- No width conversion: `D` is stored and returned bit-exact.

## Timing

- Write latency: 1 edge. Data written at edge n is readable by a request presented in cycle n+1, with `Q` updated at edge n+1.
- Read latency: 1 cycle. `RE`/`RA` sampled at edge n gives `Q`/`V` valid after edge n.
- Back-to-back reads give one result per cycle with no bubbles.
- No combinational path from any input to any output. All outputs are registered.

## Configuration

- Macro: `REGFILE_BYPASS_EN`.
- Defined: when `Load`=1, `WA`=`RA` (nonzero) and `RE`=1 in the same cycle, that port's `Q` returns the new `D` (write-first).
- Undefined: in the same case, `Q` returns the value held before the write (read-first). The new value is visible from the next read onward.
- R0 returns 0 in both configurations.

## Structure

- Shared package `risc16_pkg`:
  - `WIDTH`, `AW` and `DEPTH` constants
  - `reg_addr_t` and `word_t` typedefs
  - `R0` address constant
- Sub-module `regfile_rd_port`: the IDLE/VALID state, the `Q`/`V` registers and the bypass mux. It is instantiated twice (A and B).
- The top level holds the storage array, write decode and R0 masking.

## Test plan

- Reset: assert `rst` for 2 cycles, then read all 8 addresses on A and B -> every `Q`=0x0000 with `V`=1 one cycle after each request; `V`=0 throughout reset.
- Write/read: write 0x2468 to R1, 0x1234 to R2, 0x5670 to R3 and 0x1357 to R7 on consecutive cycles, then read R1/R2/R3/R7 back-to-back on A while B reads them in reverse order -> correct values, one per cycle, `VA`=`VB`=1 continuously.
- R0: write 0x0A0A to R0, then read R0 -> `Q`=0x0000.
- Same-cycle hazard: R4=0x0B0B; in one cycle write 0x0C0C to R4 and read R4 on A -> `QA`=0x0C0C with `REGFILE_BYPASS_EN`, 0x0B0B without; the next read returns 0x0C0C in both cases.
- Valid handshake: `RE_A` pulsed 1-0-1 -> `VA` follows 1-0-1 delayed by one cycle; `QA` holds its prior value during the 0 cycle.
- Reset mid-operation: R5=0x0D0D with continuous reads of R5; assert `rst` for 1 cycle -> `QA`=0, `VA`=0 after that edge; subsequent R5 reads return 0x0000.

Source files
------------

// File: rtl/risc16_pkg.sv
//------------------------------------------------------------------------------
// risc16_pkg : shared constants, typedefs and read-port state encoding
//              for the RISC16bit register file.
// Revision   : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package risc16_pkg;

  localparam int WIDTH = 16;
  localparam int DEPTH = 8;
  localparam int AW    = 3;

  typedef logic [AW-1:0]    reg_addr_t;
  typedef logic [WIDTH-1:0] word_t;

  localparam reg_addr_t R0 = '0;

  typedef enum logic {
    RD_IDLE  = 1'b0,
    RD_VALID = 1'b1
  } rd_state_e;

endpackage

`default_nettype wire

// File: rtl/regfile_rd_port.sv
//------------------------------------------------------------------------------
// regfile_rd_port : one registered read port (IDLE/VALID state, Q/V
//                   registers, same-cycle write bypass mux).
// Config          : REGFILE_BYPASS_EN selects write-first on a same-cycle hit.
// Revision        : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module regfile_rd_port #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             re_i,
  input  logic             wr_hit_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [WIDTH-1:0] rdata_i,
  output logic [WIDTH-1:0] q_o,
  output logic             v_o
);
  import risc16_pkg::*;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  rd_state_e        state_q;
  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] data_d;

  // wr_hit_i already excludes R0, so R0 never picks up write data here.
  assign data_d = (BYPASS && wr_hit_i) ? wdata_i : rdata_i;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RD_IDLE;
      q_q     <= '0;
    end else begin
      case (state_q)
        RD_IDLE:  state_q <= re_i ? RD_VALID : RD_IDLE;
        RD_VALID: state_q <= re_i ? RD_VALID : RD_IDLE;
        default:  state_q <= RD_IDLE;
      endcase
      if (re_i) begin
        q_q <= data_d;
      end
    end
  end

  assign q_o = q_q;
  assign v_o = (state_q == RD_VALID);

endmodule

`default_nettype wire

// File: rtl/regfile_read_8x16.sv
//------------------------------------------------------------------------------
// regfile_read_8x16 : 8 x 16 register file, R0 hardwired to zero, with two
//                     independent registered read ports.
// Config            : REGFILE_BYPASS_EN (write-first same-cycle read).
// Revision          : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module regfile_read_8x16 #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             Load,
  input  logic [AW-1:0]    WA,
  input  logic [WIDTH-1:0] D,
  input  logic             RE_A,
  input  logic [AW-1:0]    RA_A,
  output logic [WIDTH-1:0] QA,
  output logic             VA,
  input  logic             RE_B,
  input  logic [AW-1:0]    RA_B,
  output logic [WIDTH-1:0] QB,
  output logic             VB
);
  import risc16_pkg::*;

  logic [WIDTH-1:0] regs_q [DEPTH];
  logic             wr_en;
  logic [WIDTH-1:0] rdata_a, rdata_b;
  logic             hit_a, hit_b;

  assign wr_en = Load && (WA != AW'(R0));

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= '0;
      end
    end else if (wr_en) begin
      regs_q[WA] <= D;
    end
  end

  // R0 is masked on the read side so it reads zero regardless of storage.
  assign rdata_a = (RA_A == AW'(R0)) ? '0 : regs_q[RA_A];
  assign rdata_b = (RA_B == AW'(R0)) ? '0 : regs_q[RA_B];

  assign hit_a = wr_en && (WA == RA_A);
  assign hit_b = wr_en && (WA == RA_B);

  regfile_rd_port #(.WIDTH(WIDTH)) u_port_a (
    .clk      (clk),
    .rst      (rst),
    .re_i     (RE_A),
    .wr_hit_i (hit_a),
    .wdata_i  (D),
    .rdata_i  (rdata_a),
    .q_o      (QA),
    .v_o      (VA)
  );

  regfile_rd_port #(.WIDTH(WIDTH)) u_port_b (
    .clk      (clk),
    .rst      (rst),
    .re_i     (RE_B),
    .wr_hit_i (hit_b),
    .wdata_i  (D),
    .rdata_i  (rdata_b),
    .q_o      (QB),
    .v_o      (VB)
  );

endmodule

`default_nettype wire

// File: tb/tb_regfile_read_8x16.sv
//------------------------------------------------------------------------------
// tb_regfile_read_8x16 : scoreboard bench for regfile_read_8x16.
// Revision             : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_regfile_read_8x16;

  logic        clk = 1'b0;
  logic        rst;
  logic        Load;
  logic [2:0]  WA;
  logic [15:0] D;
  logic        RE_A, RE_B;
  logic [2:0]  RA_A, RA_B;
  logic [15:0] QA, QB;
  logic        VA, VB;

  always #5 clk = ~clk;

  regfile_read_8x16 dut (
    .clk  (clk),
    .rst  (rst),
    .Load (Load),
    .WA   (WA),
    .D    (D),
    .RE_A (RE_A),
    .RA_A (RA_A),
    .QA   (QA),
    .VA   (VA),
    .RE_B (RE_B),
    .RA_B (RA_B),
    .QB   (QB),
    .VB   (VB)
  );

  typedef struct packed {
    logic        v;
    logic [15:0] q;
  } exp_t;

  exp_t        sb_a[$];
  exp_t        sb_b[$];
  logic [15:0] mem [8];
  logic [15:0] last_a, last_b;
  int          n_tests = 0;
  int          n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic logic [15:0] model_rd(input logic [2:0] ra);
    if (ra == 3'd0) return 16'h0000;
`ifdef REGFILE_BYPASS_EN
    if (Load && WA == ra) return D;
`endif
    return mem[ra];
  endfunction

  // Push expectations for the current inputs, clock once, then pop and compare.
  task automatic cyc(input string tag);
    exp_t ea, eb, ga, gb;
    if (rst) begin
      ea = '0;
      eb = '0;
    end else begin
      ea.v = RE_A;
      ea.q = RE_A ? model_rd(RA_A) : last_a;
      eb.v = RE_B;
      eb.q = RE_B ? model_rd(RA_B) : last_b;
    end
    last_a = ea.q;
    last_b = eb.q;
    sb_a.push_back(ea);
    sb_b.push_back(eb);
    @(posedge clk);
    #1;
    if (rst) begin
      for (int i = 0; i < 8; i++) mem[i] = 16'h0000;
    end else if (Load && WA != 3'd0) begin
      mem[WA] = D;
    end
    if (sb_a.size() == 0 || sb_b.size() == 0) begin
      chk({tag, "/sb_empty"}, 32'd0, 32'd1);
    end else begin
      ga = sb_a.pop_front();
      gb = sb_b.pop_front();
      chk({tag, "/VA"}, {31'd0, VA}, {31'd0, ga.v});
      chk({tag, "/QA"}, {16'd0, QA}, {16'd0, ga.q});
      chk({tag, "/VB"}, {31'd0, VB}, {31'd0, gb.v});
      chk({tag, "/QB"}, {16'd0, QB}, {16'd0, gb.q});
    end
    @(negedge clk);
  endtask

  task automatic drv(input string tag, input logic ld, input logic [2:0] wa,
                     input logic [15:0] d, input logic rea, input logic [2:0] raa,
                     input logic reb, input logic [2:0] rab);
    Load = ld;
    WA   = wa;
    D    = d;
    RE_A = rea;
    RA_A = raa;
    RE_B = reb;
    RA_B = rab;
    cyc(tag);
  endtask

  logic [2:0]  wr_addr [4];
  logic [15:0] wr_data [4];

  initial begin
    rst  = 1'b1;
    last_a = 16'h0000;
    last_b = 16'h0000;
    for (int i = 0; i < 8; i++) mem[i] = 16'hFFFF;
    wr_addr = '{3'd1, 3'd2, 3'd3, 3'd7};
    wr_data = '{16'h2468, 16'h1234, 16'h5670, 16'h1357};
    @(negedge clk);

    // Reset for two cycles, with a write and reads requested to prove priority.
    drv("rst0", 1'b1, 3'd1, 16'hBEEF, 1'b1, 3'd1, 1'b1, 3'd1);
    drv("rst1", 1'b1, 3'd2, 16'hBEEF, 1'b1, 3'd2, 1'b1, 3'd2);
    rst = 1'b0;

    for (int i = 0; i < 8; i++) begin
      drv("rd_init", 1'b0, 3'd0, 16'h0, 1'b1, 3'(i), 1'b1, 3'(7 - i));
    end

    for (int i = 0; i < 4; i++) begin
      drv("wr", 1'b1, wr_addr[i], wr_data[i], 1'b0, 3'd0, 1'b0, 3'd0);
    end
    for (int i = 0; i < 4; i++) begin
      drv("rd_b2b", 1'b0, 3'd0, 16'h0, 1'b1, wr_addr[i], 1'b1, wr_addr[3 - i]);
    end

    drv("r0_wr", 1'b1, 3'd0, 16'h0A0A, 1'b0, 3'd0, 1'b0, 3'd0);
    drv("r0_rd", 1'b0, 3'd0, 16'h0, 1'b1, 3'd0, 1'b1, 3'd0);
    drv("r0_wrrd", 1'b1, 3'd0, 16'h0A0A, 1'b1, 3'd0, 1'b1, 3'd0);

    drv("r4_init", 1'b1, 3'd4, 16'h0B0B, 1'b0, 3'd0, 1'b0, 3'd0);
    drv("hazard", 1'b1, 3'd4, 16'h0C0C, 1'b1, 3'd4, 1'b1, 3'd3);
    drv("hazard_nx", 1'b0, 3'd0, 16'h0, 1'b1, 3'd4, 1'b1, 3'd4);

    drv("hs1", 1'b0, 3'd0, 16'h0, 1'b1, 3'd2, 1'b0, 3'd0);
    drv("hs0", 1'b1, 3'd6, 16'h6666, 1'b0, 3'd7, 1'b0, 3'd0);
    drv("hs1b", 1'b0, 3'd0, 16'h0, 1'b1, 3'd6, 1'b1, 3'd6);

    drv("r5_wr", 1'b1, 3'd5, 16'h0D0D, 1'b0, 3'd0, 1'b0, 3'd0);
    drv("r5_rd", 1'b0, 3'd0, 16'h0, 1'b1, 3'd5, 1'b1, 3'd5);
    drv("r5_rd", 1'b0, 3'd0, 16'h0, 1'b1, 3'd5, 1'b1, 3'd5);
    rst = 1'b1;
    drv("mid_rst", 1'b0, 3'd0, 16'h0, 1'b1, 3'd5, 1'b1, 3'd5);
    rst = 1'b0;
    drv("post_rst", 1'b0, 3'd0, 16'h0, 1'b1, 3'd5, 1'b1, 3'd1);
    drv("post_rst", 1'b0, 3'd0, 16'h0, 1'b1, 3'd5, 1'b0, 3'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
